// File: rtl/smem_pkg.sv
// Shared types and defaults for the SMEM output arbiter slice.
package smem_pkg;

   localparam int DATA_W    = 512;
   localparam int NUM_BANKS = 4;
   localparam int IDX_W     = $clog2(NUM_BANKS);

   // One host beat tagged with the bank it came from
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [IDX_W-1:0]  bank_idx;
   } beat_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/smem_output_arbiter_if.sv
// Bank-side and host-side bundle of the SMEM output arbiter.
// With ARB_PERF_CNT_EN defined the bundle also carries the perf counters.
interface smem_output_arbiter_if #(
   parameter int NUM_BANKS = 4,
   parameter int DATA_W    = 512,
   parameter int IDX_W     = 2
);
   logic [NUM_BANKS-1:0]        bank_req;
   logic [NUM_BANKS-1:0]        bank_permit;
   logic [NUM_BANKS-1:0]        bank_stall;
   logic [NUM_BANKS-1:0]        bank_valid;
   logic [NUM_BANKS-1:0]        bank_finish;
   logic [NUM_BANKS*DATA_W-1:0] bank_data;
   logic [DATA_W-1:0]           host_data;
   logic [IDX_W-1:0]            host_bank;
   logic                        host_valid;
   logic                        host_ready;
   logic                        busy;
   logic                        batch_done;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]                 perf_beats;
   logic [31:0]                 perf_stall_cycles;

   modport master (
      input  bank_req, bank_valid, bank_finish, bank_data, host_ready,
      output bank_permit, bank_stall, host_data, host_bank, host_valid,
             busy, batch_done, perf_beats, perf_stall_cycles
   );
   modport slave (
      output bank_req, bank_valid, bank_finish, bank_data, host_ready,
      input  bank_permit, bank_stall, host_data, host_bank, host_valid,
             busy, batch_done, perf_beats, perf_stall_cycles
   );
`else
   modport master (
      input  bank_req, bank_valid, bank_finish, bank_data, host_ready,
      output bank_permit, bank_stall, host_data, host_bank, host_valid,
             busy, batch_done
   );
   modport slave (
      output bank_req, bank_valid, bank_finish, bank_data, host_ready,
      input  bank_permit, bank_stall, host_data, host_bank, host_valid,
             busy, batch_done
   );
`endif
endinterface

// File: rtl/smem_skid_fifo.sv
// First-word-fall-through skid FIFO with occupancy count.
// Head reads as zero while empty so the host bus is quiet after reset.
module smem_skid_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so push+pop on full is fine
   assign do_push = push && (!full || do_pop);
   assign count   = cnt;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // storage write, no reset needed since the head is masked when empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // pointers wrap naturally; count is one bit wider to hold DEPTH
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      cnt <= cnt + 1'b1;
         else if (!do_push && do_pop) cnt <= cnt - 1'b1;
      end
   end

   // a push into a full FIFO means the upstream stall margin was violated
   always_ff @(posedge clk) begin
      if (reset_n) assert (!(push && full && !do_pop));
   end

endmodule

// File: rtl/smem_output_arbiter.sv
// Round-robin arbiter sharing one host write channel among SMEM result banks.
// A granted bank streams a whole batch through a skid FIFO; its stall is
// raised early enough that beats already in its read pipeline still fit.
// Optional macro ARB_PERF_CNT_EN adds saturating beat/stall perf counters.
module smem_output_arbiter
   import smem_pkg::*;
#(
   parameter int NUM_BANKS    = smem_pkg::NUM_BANKS,
   parameter int DATA_W       = smem_pkg::DATA_W,
   parameter int IDX_W        = smem_pkg::IDX_W,
   parameter int SKID_DEPTH   = 8,
   parameter int STALL_MARGIN = 4
)(
   input logic                  clk,
   input logic                  reset_n,
   smem_output_arbiter_if.master io
);
   localparam int CNT_W = $clog2(SKID_DEPTH) + 1;

   arb_state_e             state;
   logic [IDX_W-1:0]       cur, rr_ptr, pick;
   logic [NUM_BANKS-1:0]   served, permit, stall, elig, done_set;
   logic                   any_elig, all_served_q, batch_done_q;
   logic                   push, pop, low_space, in_xfer;
   logic                   fifo_empty, fifo_full;
   logic [CNT_W-1:0]       fifo_count;
   logic [DATA_W+IDX_W-1:0] fifo_din, fifo_dout;

   assign elig      = io.bank_req & ~served;
   assign in_xfer   = (state == GRANT) || (state == DRAIN);
   assign push      = in_xfer && io.bank_valid[cur];
   assign fifo_din  = {cur, io.bank_data[cur*DATA_W +: DATA_W]};
   assign pop       = !fifo_empty && io.host_ready;
   assign low_space = (CNT_W'(SKID_DEPTH) - fifo_count) < CNT_W'(STALL_MARGIN);
   assign done_set  = (state == DONE) ? (NUM_BANKS'(1) << cur) : '0;

   // first eligible bank at or after rr_ptr; descending scan lets the nearest win
   always_comb begin
      any_elig = 1'b0;
      pick     = rr_ptr;
      for (int k = NUM_BANKS - 1; k >= 0; k--) begin
         if (elig[(int'(rr_ptr) + k) % NUM_BANKS]) begin
            any_elig = 1'b1;
            pick     = IDX_W'((int'(rr_ptr) + k) % NUM_BANKS);
         end
      end
   end

   // only the granted bank in GRANT may run; everyone else is held
   always_comb begin
      stall = '1;
      if (state == GRANT) stall[cur] = low_space;
   end

   // grant FSM plus served mask, round-robin pointer and batch pulse
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         cur          <= '0;
         rr_ptr       <= '0;
         permit       <= '0;
         served       <= '0;
         all_served_q <= 1'b0;
         batch_done_q <= 1'b0;
      end else begin
         // a dropped request forgets the bank's service, even on completion
         served       <= (served | done_set) & io.bank_req;
         all_served_q <= &served;
         batch_done_q <= (&served) && !all_served_q;
         case (state)
            IDLE: if (any_elig) begin
               cur    <= pick;
               permit <= NUM_BANKS'(1) << pick;
               state  <= GRANT;
            end
            GRANT: if (io.bank_finish[cur]) state <= DRAIN;
            // late beats from the bank pipeline still land before release
            DRAIN: if (fifo_empty && !io.bank_valid[cur]) begin
               permit <= '0;
               state  <= DONE;
            end
            DONE: begin
               rr_ptr <= (int'(cur) == NUM_BANKS - 1) ? '0 : cur + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   smem_skid_fifo #(
      .WIDTH (DATA_W + IDX_W),
      .DEPTH (SKID_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (fifo_din),
      .pop     (pop),
      .dout    (fifo_dout),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign io.bank_permit = permit;
   assign io.bank_stall  = stall;
   assign io.host_valid  = !fifo_empty;
   assign io.host_data   = fifo_dout[DATA_W-1:0];
   assign io.host_bank   = fifo_dout[DATA_W +: IDX_W];
   assign io.busy        = (state != IDLE);
   assign io.batch_done  = batch_done_q;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_beats_q, perf_stall_q;

   // saturating counters: host pops and stalled GRANT cycles
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_beats_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (pop && !(&perf_beats_q)) perf_beats_q <= perf_beats_q + 1'b1;
         if ((state == GRANT) && stall[cur] && !(&perf_stall_q))
            perf_stall_q <= perf_stall_q + 1'b1;
      end
   end

   assign io.perf_beats        = perf_beats_q;
   assign io.perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_smem_output_arbiter.sv
// Bench for smem_output_arbiter: behavioural banks with a 2-deep read
// pipeline, random host backpressure and a beat scoreboard.
module tb_smem_output_arbiter;
   import smem_pkg::*;

   localparam int NB     = 4;
   localparam int DW     = 512;
   localparam int IW     = 2;
   localparam int DEPTH  = 8;
   localparam int MARGIN = 4;
   localparam int BUDGET = 2000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          tests = 0;
   int          fails = 0;
   int          rr_m = 0;
   int          beats_m = 0;
   int          stall_m = 0;
   logic [31:0] seed = '0;
   beat_t       exp_q [$];

   always #5 clk = ~clk;

   smem_output_arbiter_if #(.NUM_BANKS(NB), .DATA_W(DW), .IDX_W(IW)) bus ();

   smem_output_arbiter #(
      .NUM_BANKS(NB), .DATA_W(DW), .IDX_W(IW),
      .SKID_DEPTH(DEPTH), .STALL_MARGIN(MARGIN)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .io      (bus)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] gen(input int b, input int n);
      logic [DW-1:0] d;
      for (int w = 0; w < DW/32; w++)
         d[w*32 +: 32] = seed ^ (32'(b) << 28) ^ (32'(n) << 12) ^ (32'(w) * 32'h9e3779b9);
      return d;
   endfunction

   task automatic drive_noise(input logic [NB-1:0] perm);
      for (int i = 0; i < NB*DW/32; i++) bus.bank_data[i*32 +: 32] = $urandom();
      bus.bank_valid  = NB'($urandom()) & ~perm;
      bus.bank_finish = NB'($urandom()) & ~perm;
   endtask

   task automatic run_scn(input logic [NB-1:0] mask, input int len, input bit rnd_len,
                          input int rmode, input int abort_occ);
      int order [$];
      int remain [NB];
      int issued [NB];
      int k, occ, pulses, b, j, cyc;
      bit was_perm, in_grant, fin, pv0, pv1, rdy, issue, aborted;
      logic [DW-1:0] pd0, pd1;
      logic [NB-1:0] perm, stl;
      beat_t bt;
      k = 0; occ = 0; pulses = 0; b = 0; cyc = 0;
      was_perm = 0; in_grant = 0; fin = 0; pv0 = 0; pv1 = 0; aborted = 0;
      pd0 = '0; pd1 = '0;
      seed = $urandom();
      // expected stream: requesters in round-robin order from rr_m, whole batches
      for (int i = 0; i < NB; i++) begin
         j = (rr_m + i) % NB;
         remain[j] = 0;
         issued[j] = 0;
         if (mask[j]) begin
            remain[j] = rnd_len ? int'($urandom_range(1, 10)) : len;
            order.push_back(j);
            for (int n = 0; n < remain[j]; n++) begin
               bt.data = gen(j, n);
               bt.bank_idx = IW'(j);
               exp_q.push_back(bt);
            end
         end
      end
      rr_m = (order[order.size()-1] + 1) % NB;

      for (cyc = 0; cyc < BUDGET; cyc++) begin
         perm = bus.bank_permit;
         stl  = bus.bank_stall;
         if (abort_occ > 0 && occ >= abort_occ) begin
            aborted = 1;
            break;
         end
         if (k == order.size() && occ == 0 && perm == '0 && bus.busy === 1'b0) break;
         if (perm != '0) begin
            chk("extra_grant", k < order.size(), 1'b1);
            if (k < order.size()) b = order[k];
            if (!was_perm) begin
               in_grant = 1; fin = 0; pv0 = 0; pv1 = 0;
            end
            chk("permit", perm, 1 << b);
            chk("busy", bus.busy, 1'b1);
         end else if (was_perm) k++;
         if (cyc == 1) chk("grant_latency", perm, 1 << order[0]);
         chk("stall_other", stl | perm, {NB{1'b1}});
         if (perm != '0 && in_grant) chk("stall_grant", stl[b], (DEPTH - occ) < MARGIN);
         if (perm != '0 && !in_grant) chk("stall_drain", stl[b], 1'b1);
         chk("host_valid", bus.host_valid, occ != 0);
         if (perm != '0 && in_grant && stl[b]) stall_m++;
         pulses += int'(bus.batch_done);

         case (rmode)
            0:       rdy = 1;
            1:       rdy = ($urandom_range(0, 3) != 0);
            2:       rdy = (cyc >= 20);
            default: rdy = 0;
         endcase
         bus.host_ready = rdy;
         if (occ != 0 && rdy) begin
            if (exp_q.size() == 0) chk("spurious_beat", 1'b1, 1'b0);
            else begin
               bt = exp_q.pop_front();
               chk("host_data", bus.host_data, bt.data);
               chk("host_bank", bus.host_bank, bt.bank_idx);
            end
            occ--;
            beats_m++;
         end

         drive_noise(perm);
         bus.bank_req = mask;
         if (perm != '0) begin
            bus.bank_valid[b] = pv1;
            bus.bank_data[b*DW +: DW] = pd1;
            if (pv1) occ++;
            issue = in_grant && !stl[b] && (issued[b] < remain[b]);
            pv1 = pv0; pd1 = pd0; pv0 = issue;
            if (issue) begin
               pd0 = gen(b, issued[b]);
               issued[b]++;
            end
            // finish only once the remaining beats will arrive back to back
            if (issued[b] == remain[b] && (pv1 || !pv0)) fin = 1;
            bus.bank_finish[b] = fin;
            if (fin) in_grant = 0;
         end
         was_perm = (perm != '0);
         @(posedge clk); #1;
      end

      if (!aborted) begin
         chk("timeout", cyc < BUDGET, 1'b1);
         for (int h = 0; h < 5; h++) begin
            drive_noise('0);
            bus.bank_req = (h < 3) ? mask : '0;
            bus.host_ready = 1'b1;
            chk("no_regrant", bus.bank_permit, '0);
            chk("idle_valid", bus.host_valid, 1'b0);
            pulses += int'(bus.batch_done);
            @(posedge clk); #1;
         end
         chk("batch_done", pulses, mask == {NB{1'b1}});
         chk("beats_left", exp_q.size(), 0);
`ifdef ARB_PERF_CNT_EN
         chk("perf_beats", bus.perf_beats, beats_m);
         chk("perf_stall", bus.perf_stall_cycles, stall_m);
`endif
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_permit", bus.bank_permit, '0);
      chk("rst_stall", bus.bank_stall, {NB{1'b1}});
      chk("rst_host_valid", bus.host_valid, 1'b0);
      chk("rst_host_data", bus.host_data, '0);
      chk("rst_host_bank", bus.host_bank, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_batch_done", bus.batch_done, 1'b0);
`ifdef ARB_PERF_CNT_EN
      chk("rst_perf_beats", bus.perf_beats, '0);
      chk("rst_perf_stall", bus.perf_stall_cycles, '0);
`endif
   endtask

   initial begin
      logic [NB-1:0] m;
      bus.bank_req = '0; bus.bank_valid = '0; bus.bank_finish = '0;
      bus.bank_data = '0; bus.host_ready = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state();
      reset_n = 1'b1;

      // single bank, five beats, no backpressure
      run_scn(4'b0001, 5, 0, 0, 0);
      // all banks, three beats each
      run_scn(4'b1111, 3, 0, 0, 0);
      // twelve beats with host stalled for the first 20 cycles
      run_scn(4'b0100, 12, 0, 2, 0);
      // random masks, lengths and host readiness
      for (int r = 0; r < 8; r++) begin
         m = NB'($urandom_range(1, 15));
         run_scn(m, 0, 1, 1, 0);
      end
      run_scn(4'b1111, 0, 1, 1, 0);

      // reset while a grant is active with beats buffered
      run_scn(4'b0010, 8, 0, 3, 3);
      reset_n = 1'b0;
      bus.bank_req = '0; bus.bank_valid = '0; bus.bank_finish = '0;
      bus.host_ready = 1'b0;
      @(posedge clk); #1;
      chk_reset_state();
      reset_n = 1'b1;
      exp_q.delete();
      rr_m = 0; beats_m = 0; stall_m = 0;
      run_scn(4'b1111, 2, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
